// File: rtl/msdap_pkg.sv
// msdap_pkg: shared types, defaults and sample-to-bit mapping for the frame deserialiser
package msdap_pkg;
   typedef enum logic {IDLE, SHIFT} state_t;
   localparam int DEF_WIDTH    = 16;
   localparam int DEF_CHANNELS = 2;
   localparam int CNT_W        = $clog2(DEF_WIDTH);
   function automatic int bit_pos(input int k, input int width, input bit msb_first);
      return msb_first ? width - 1 - k : k;
   endfunction
endpackage

// File: rtl/frame_sipo_n_if.sv
// frame_sipo_n_if: serial input, handshake and status bundle of the frame deserialiser
interface frame_sipo_n_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2
);
   logic                      Frame;
   logic [CHANNELS-1:0]       Din;
   logic                      Out_ready;
   logic [CHANNELS*WIDTH-1:0] Data_out;
   logic                      Out_valid;
   logic                      Frame_err;
   logic                      Overrun;
   logic                      Busy;
   modport slave (
      input  Frame, Din, Out_ready,
      output Data_out, Out_valid, Frame_err, Overrun, Busy
   );
   modport master (
      output Frame, Din, Out_ready,
      input  Data_out, Out_valid, Frame_err, Overrun, Busy
   );
endinterface

// File: rtl/sipo_lane.sv
// sipo_lane: one lane's indexed capture register; o_next already holds the bit captured this edge
module sipo_lane
   import msdap_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CW        = $clog2(WIDTH)
) (
   input  logic             Dclk,
   input  logic             Clear,
   input  logic             i_en,
   input  logic [CW-1:0]    i_idx,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_next
);
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    w_pos;
   assign w_pos = CW'(bit_pos(int'(i_idx), WIDTH, MSB_FIRST));
   always_comb begin
      o_next = r_shift;
      if (i_en) o_next[w_pos] = i_bit;
   end
   always_ff @(negedge Dclk or negedge Clear)
      if (!Clear) r_shift <= '0;
      else        r_shift <= o_next;
endmodule

// File: rtl/frame_sipo_n.sv
// frame_sipo_n: frame-synchronised multi-lane deserialiser with valid/ready holding register
module frame_sipo_n
   import msdap_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic           Dclk,
   input logic           Clear,
   frame_sipo_n_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   state_t                    r_state, w_state_nx;
   logic [CW-1:0]             r_cnt, w_cnt_nx, w_idx;
   logic [CHANNELS*WIDTH-1:0] r_data, w_word;
   logic                      r_valid, r_ferr, r_ovr;
   logic                      w_cap, w_done, w_ferr;
   // A Frame always restarts the word at sample 0, whatever the state
   assign w_cap = bus.Frame | (r_state == SHIFT);
   assign w_idx = bus.Frame ? '0 : r_cnt;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      sipo_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
         .Dclk   (Dclk),
         .Clear  (Clear),
         .i_en   (w_cap),
         .i_idx  (w_idx),
         .i_bit  (bus.Din[c]),
         .o_next (w_word[c*WIDTH +: WIDTH])
      );
   end
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_ferr     = 1'b0;
      w_done     = 1'b0;
      if (bus.Frame) begin
         w_state_nx = SHIFT;
         w_cnt_nx   = CW'(1);
         w_ferr     = (r_state == SHIFT);
      end else if (r_state == SHIFT) begin
         w_done     = (r_cnt == CW'(WIDTH - 1));
         w_state_nx = w_done ? IDLE : SHIFT;
         w_cnt_nx   = w_done ? '0 : r_cnt + 1'b1;
      end
   end
   always_ff @(negedge Dclk or negedge Clear)
      if (!Clear) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_ferr  <= w_ferr;
         r_ovr   <= w_done & r_valid & ~bus.Out_ready;
         r_valid <= w_done | (r_valid & ~bus.Out_ready);
         if (w_done) r_data <= w_word;
      end
   assign bus.Data_out  = r_data;
   assign bus.Out_valid = r_valid;
   assign bus.Frame_err = r_ferr;
   assign bus.Overrun   = r_ovr;
   assign bus.Busy      = (r_state == SHIFT);
endmodule
